// File: rtl/addsub_limb_seq.sv
// addsub_limb_seq: limb-serial wide add/sub sequencer around an external N-bit adder; ADDSUB_SEQ_OVF_EN builds signed-overflow out_ovf
module addsub_limb_seq #(
  parameter int N = 5,
  parameter int LIMBS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*LIMBS-1:0]   in_a,
  input  logic [N*LIMBS-1:0]   in_b,
  input  logic                 in_sub,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_ci,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_co,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*LIMBS-1:0]   out_result,
  output logic                 out_carry,
  output logic                 out_ovf
);
  localparam int W = N * LIMBS;
  localparam int IW = LIMBS > 1 ? $clog2(LIMBS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_q, b_q;
  logic carry_q;
  logic [IW-1:0] idx;
  logic last;
  assign last = idx == IW'(LIMBS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    add_a = state == RUN ? a_q[idx*N +: N] : '0;
    add_b = state == RUN ? b_q[idx*N +: N] : '0;
    add_ci = state == RUN ? carry_q : 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      carry_q <= 1'b0;
      idx <= '0;
      out_result <= '0;
      out_carry <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q <= in_a;
      b_q <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub;
      idx <= '0;
    end else if (state == RUN) begin
      out_result[idx*N +: N] <= add_sum;
      carry_q <= add_co;
      idx <= last ? idx : idx + 1'b1;
      if (last) out_carry <= add_co;
    end
`ifdef ADDSUB_SEQ_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_q <= 1'b0;
    else if (state == RUN && last) ovf_q <= (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_addsub_limb_seq.sv
// tb_addsub_limb_seq: directed self-checking bench for addsub_limb_seq with a behavioural adder
module tb_addsub_limb_seq;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_sub = 0;
  logic [19:0] in_a = 0, in_b = 0;
  logic [4:0] add_a, add_b, add_sum;
  logic add_ci, add_co;
  logic out_valid, out_ready = 1, out_carry, out_ovf;
  logic [19:0] out_result;
  int n_cmp = 0, n_fail = 0;
`ifdef ADDSUB_SEQ_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  always #5 clk = ~clk;
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {5'b0, add_ci};
  addsub_limb_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_ovf(out_ovf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [19:0] a, input logic [19:0] b, input logic s);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_sub = s;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_done(input string tag);
    int cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 5);
  endtask
  task automatic finish_op(input string tag, input logic [19:0] r, input logic c, input logic o);
    chk({tag, "_result"}, out_result, r);
    chk({tag, "_carry"}, out_carry, c);
    chk({tag, "_ovf"}, out_ovf, o & OVF);
    @(negedge clk);
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_out_valid_after"}, out_valid, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_carry_ovf", {out_carry, out_ovf}, 0);
    chk("rst_adder_drive", {add_a, add_b, add_ci}, 0);
    rst = 0;
    start(20'hFFFFF, 20'h00001, 0);
    chk("add1_in_ready_busy", in_ready, 0);
    wait_done("add1");
    finish_op("add1", 20'h00000, 1, 0);
    start(20'h00005, 20'h00007, 1);
    chk("sub1_first_limb", {add_a, add_b, add_ci}, {5'h05, 5'h18, 1'b1});
    wait_done("sub1");
    finish_op("sub1", 20'hFFFFE, 0, 0);
    start(20'h7FFFF, 20'h00001, 0);
    wait_done("add_ovf");
    finish_op("add_ovf", 20'h80000, 0, 1);
    start(20'h80000, 20'h00001, 1);
    wait_done("sub_ovf");
    finish_op("sub_ovf", 20'h7FFFF, 1, 1);
    out_ready = 0;
    start(20'h00003, 20'h00004, 0);
    wait_done("bp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", {out_carry, out_result}, {1'b0, 20'h00007});
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    start(20'h11111, 20'h22222, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrun_rst_state", {in_ready, out_valid}, 2'b10);
    chk("midrun_rst_result", out_result, 0);
    chk("midrun_rst_drive", {add_a, add_b, add_ci}, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrun_no_stale_valid", out_valid, 0);
    end
    start(20'h12345, 20'h0000A, 0);
    wait_done("post_rst");
    finish_op("post_rst", 20'h1234F, 0, 0);
    @(negedge clk);
    in_a = 20'h00010;
    in_b = 20'h00020;
    in_sub = 0;
    in_valid = 1;
    @(posedge clk);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      in_valid = t[0];
      in_a = 20'hFFFFF;
      in_b = 20'hFFFFF;
      chk("b2b_busy_in_ready", in_ready, 0);
    end
    chk("b2b_first_valid", out_valid, 1);
    chk("b2b_first_result", out_result, 20'h00030);
    in_valid = 0;
    @(negedge clk);
    chk("b2b_idle_again", in_ready, 1);
    in_a = 20'h0ABCD;
    in_b = 20'h01234;
    in_sub = 1;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    chk("b2b_second_accepted", in_ready, 0);
    wait_done("b2b2");
    finish_op("b2b2", 20'h09999, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
